// File: rtl/mul_div_unit.sv
// Purpose: iterative MIPS multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency: mult/div results land in hi/lo with a one-cycle done pulse WIDTH+1 edges after start; MTHI/MTLO take one edge.
// Backpressure: busy stays high from accept through FINISH; any start seen while busy is dropped.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   counter;
  logic [WIDTH-1:0] acc;   // running high half (mult) or partial remainder (div)
  logic [WIDTH-1:0] q;     // multiplier being consumed (mult) or dividend/quotient (div)
  logic [WIDTH-1:0] m;     // multiplicand or divisor magnitude
  logic            is_div, neg_q, neg_r, dbz;

  logic            is_arith, is_div_op, signed_op, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_sh, div_sub;
  logic            div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy = (state != IDLE);

  // Decode the request and form operand magnitudes for the signed ops.
  always_comb begin
    is_arith  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    sa        = signed_op & a[WIDTH-1];
    sb        = signed_op & b[WIDTH-1];
    a_mag     = sa ? -a : a;
    b_mag     = sb ? -b : b;
  end

  // One shift-add step and one restoring-divide step, plus the final sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    div_sh   = {acc, q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, m});
    div_sub  = div_sh - {1'b0, m};
    prod_fix = neg_q ? -{acc, q} : {acc, q};
    quo_fix  = dbz ? {WIDTH{1'b1}} : (neg_q ? -q : q);
    rem_fix  = neg_r ? -acc : acc;
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE -> RUN on an accepted mult/div, WIDTH iterations, then one FINISH cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_arith) state_nxt = RUN;
      RUN:     if (counter == CW'(WIDTH-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in RUN, commit hi/lo only in FINISH.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      counter <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && is_arith) begin
            counter <= '0;
            acc     <= '0;
            is_div  <= is_div_op;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            dbz     <= (b == '0);
            q       <= is_div_op ? a_mag : b_mag;
            m       <= is_div_op ? b_mag : a_mag;
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        RUN: begin
          counter <= counter + 1'b1;
          if (is_div) begin
            acc <= div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
        end
        FINISH: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
